// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared types and constants for the two-requester ALU arbiter:
//   FSM state encoding, ALU op-code values and response flag bit positions.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  // Bit positions inside rsp_flags = {cout, ow, neg, zero}
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OW   = 2;
  localparam int FLAG_COUT = 3;

  // Only the arithmetic ops produce meaningful ALU flags.
  function automatic logic op_has_flags(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin grant.
//   i_valid : request vector, bit i = requester i
//   i_prio  : preferred requester this round
//   o_grant : one-hot grant, zero when nothing is valid
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_prio,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_valid[i_prio]) begin
      o_grant[i_prio] = 1'b1;
    end else if (i_valid[~i_prio]) begin
      o_grant[~i_prio] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational ALU between two requesters. One op is
//   in flight at a time; grants alternate round-robin so neither side starves.
//
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : per-requester request handshake
//   req_op/req_x/req_y/req_c : packed per-requester op and operands
//   rsp_valid/rsp_ready   : per-requester response handshake
//   rsp_data/rsp_flags    : shared response bus, flags = {cout, ow, neg, zero}
//   alu_ctrl/alu_x/alu_y/alu_c : to the ALU, driven only in EXEC
//   alu_s/alu_cout/alu_ow/alu_neg/alu_zero : from the ALU
//   grant_cnt             : saturating completed-op count per requester
//
//   state | meaning
//   IDLE  | offering a grant to the round-robin winner
//   EXEC  | ALU driven from latched op; result captured at cycle end
//   RESP  | response held for owner until rsp_ready
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OP_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*OP_W-1:0]    req_op,
  input  logic [2*WIDTH-1:0]   req_x,
  input  logic [2*WIDTH-1:0]   req_y,
  input  logic [1:0]           req_c,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic [3:0]           rsp_flags,
  output logic [OP_W-1:0]      alu_ctrl,
  output logic [WIDTH-1:0]     alu_x,
  output logic [WIDTH-1:0]     alu_y,
  output logic                 alu_c,
  input  logic [WIDTH-1:0]     alu_s,
  input  logic                 alu_cout,
  input  logic                 alu_ow,
  input  logic                 alu_neg,
  input  logic                 alu_zero,
  output logic [2*CNT_W-1:0]   grant_cnt
);

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_owner;
  logic                     r_rr;
  logic [OP_W-1:0]          r_op;
  logic [WIDTH-1:0]         r_x;
  logic [WIDTH-1:0]         r_y;
  logic                     r_c;
  logic [WIDTH-1:0]         r_data;
  logic [3:0]               r_flags;
  logic [1:0][CNT_W-1:0]    r_cnt;

  logic [1:0]               w_grant;
  logic                     w_win;
  logic                     w_hs;
  logic                     w_rsp_hs;
  logic [3:0]               w_alu_flags;

  rr_arb2 u_rr_arb2 (
    .i_valid (req_valid),
    .i_prio  (r_rr),
    .o_grant (w_grant)
  );

  assign w_win    = w_grant[1];
  assign w_hs     = (r_state == ST_IDLE) && |(req_valid & w_grant);
  assign w_rsp_hs = (r_state == ST_RESP) && rsp_ready[r_owner];

  always_comb begin
    w_alu_flags            = 4'b0000;
    w_alu_flags[FLAG_COUT] = alu_cout;
    w_alu_flags[FLAG_OW]   = alu_ow;
    w_alu_flags[FLAG_NEG]  = alu_neg;
    w_alu_flags[FLAG_ZERO] = alu_zero;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    alu_ctrl  = '0;
    alu_x     = '0;
    alu_y     = '0;
    alu_c     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = w_grant;
        if (w_hs) w_next = ST_EXEC;
      end
      ST_EXEC: begin
        alu_ctrl = r_op;
        alu_x    = r_x;
        alu_y    = r_y;
        alu_c    = r_c;
        w_next   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[r_owner] = 1'b1;
        if (w_rsp_hs) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_rr    <= 1'b0;
      r_op    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_c     <= 1'b0;
      r_data  <= '0;
      r_flags <= 4'b0000;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_owner <= w_win;
        r_rr    <= ~w_win;
        r_op    <= w_win ? req_op[2*OP_W-1:OP_W]   : req_op[OP_W-1:0];
        r_x     <= w_win ? req_x[2*WIDTH-1:WIDTH]  : req_x[WIDTH-1:0];
        r_y     <= w_win ? req_y[2*WIDTH-1:WIDTH]  : req_y[WIDTH-1:0];
        r_c     <= req_c[w_win];
      end
      if (r_state == ST_EXEC) begin
        r_data  <= alu_s;
        // Logic/compare ops leave ALU flags undriven; never forward them.
        r_flags <= op_has_flags(3'(r_op)) ? w_alu_flags : 4'b0000;
      end
      if (w_rsp_hs && (r_cnt[r_owner] != {CNT_W{1'b1}})) begin
        r_cnt[r_owner] <= r_cnt[r_owner] + 1'b1;
      end
    end
  end

  assign rsp_data  = r_data;
  assign rsp_flags = r_flags;
  assign grant_cnt = r_cnt;

endmodule
